// File: rtl/mac_stop_pkg.sv
// Shared types and index-width helpers for the mac_stop matrix-multiply controller.
package mac_stop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index width for a dimension; a dimension of 1 still needs a 1-bit index.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_stop_addr_gen.sv
// Nested i/j/k index counters for the C = A x B sequencer; each wraps at its bound-1.
module mac_stop_addr_gen
    import mac_stop_pkg::*;
#(
    parameter int unsigned M = 4,
    parameter int unsigned K = 4,
    parameter int unsigned N = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  adv_k,
    input  logic                  adv_ij,
    output logic [idx_w(M)-1:0]   i,
    output logic [idx_w(N)-1:0]   j,
    output logic [idx_w(K)-1:0]   k,
    output logic                  k_last,
    output logic                  ij_last
);

    localparam int unsigned IW = idx_w(M);
    localparam int unsigned JW = idx_w(N);
    localparam int unsigned KW = idx_w(K);

    localparam logic [IW-1:0] I_MAX = IW'(M - 1);
    localparam logic [JW-1:0] J_MAX = JW'(N - 1);
    localparam logic [KW-1:0] K_MAX = KW'(K - 1);

    assign k_last  = (k == K_MAX);
    assign ij_last = (i == I_MAX) && (j == J_MAX);

    // adv_ij finishes one C element: restart k and step j, carrying into i.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (adv_ij) begin
            k <= '0;
            if (j == J_MAX) begin
                j <= '0;
                i <= (i == I_MAX) ? '0 : i + 1'b1;
            end else begin
                j <= j + 1'b1;
            end
        end else if (adv_k) begin
            k <= k_last ? '0 : k + 1'b1;
        end
    end

endmodule

// File: rtl/mac_stop_ctrl.sv
// Matrix-multiply initiator: reads A/B from the store, accumulates dot products, writes C.
module mac_stop_ctrl
    import mac_stop_pkg::*;
#(
    parameter int unsigned M = 4,
    parameter int unsigned K = 4,
    parameter int unsigned N = 4,
    parameter int unsigned DATA_WIDTH_INIT_MATRIX = 32,
    parameter int unsigned DATA_WIDTH_RESULT_MATRIX = DATA_WIDTH_INIT_MATRIX * 2 + $clog2(K)
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                start,
    input  logic                                stop,
    output logic                                busy,
    output logic                                done,
    output logic [idx_w(M)-1:0]                 row_addr_a,
    output logic [idx_w(K)-1:0]                 col_addr_a,
    output logic [idx_w(K)-1:0]                 row_addr_b,
    output logic [idx_w(N)-1:0]                 col_addr_b,
    output logic [idx_w(M)-1:0]                 row_addr_c,
    output logic [idx_w(N)-1:0]                 col_addr_c,
    output logic                                matrix_a_re,
    output logic                                matrix_b_re,
    output logic                                matrix_c_re,
    output logic                                matrix_a_we,
    output logic                                matrix_b_we,
    output logic                                matrix_c_we,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b
);

    localparam int unsigned W  = DATA_WIDTH_INIT_MATRIX;
    localparam int unsigned RW = DATA_WIDTH_RESULT_MATRIX;

    state_t state_q, state_d;

    logic [idx_w(M)-1:0] i;
    logic [idx_w(N)-1:0] j;
    logic [idx_w(K)-1:0] k;
    logic                k_last, ij_last;
    logic                clear, adv_k, adv_ij;
    logic [2*W-1:0]      prod;
    logic [RW-1:0]       acc;

    mac_stop_addr_gen #(
        .M (M),
        .K (K),
        .N (N)
    ) u_addr_gen (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (clear),
        .adv_k   (adv_k),
        .adv_ij  (adv_ij),
        .i       (i),
        .j       (j),
        .k       (k),
        .k_last  (k_last),
        .ij_last (ij_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !stop) state_d = MAC;
            MAC:     if (stop) state_d = IDLE;
                     else if (k_last) state_d = WRITE;
            WRITE:   if (stop) state_d = IDLE;
                     else if (ij_last) state_d = DONE;
                     else state_d = MAC;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Leaving DONE also clears, so IDLE always presents zero on every output.
    assign clear  = ((state_q == IDLE) && start && !stop)
                  || ((state_q != IDLE) && stop)
                  || (state_q == DONE);
    assign adv_k  = (state_q == MAC) && !stop && !k_last;
    assign adv_ij = (state_q == WRITE) && !stop;

    assign prod = data_out_a * data_out_b;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            acc <= '0;
        end else if (state_q == MAC) begin
            acc <= ((k == '0) ? '0 : acc) + RW'(prod);
        end
    end

    assign busy        = (state_q == MAC) || (state_q == WRITE);
    assign done        = (state_q == DONE) && !stop;
    assign matrix_a_re = (state_q == MAC);
    assign matrix_b_re = (state_q == MAC);
    assign matrix_c_re = 1'b0;
    assign matrix_a_we = 1'b0;
    assign matrix_b_we = 1'b0;
    assign matrix_c_we = (state_q == WRITE) && !stop;
    assign data_in_c   = acc;

    assign row_addr_a = i;
    assign col_addr_a = k;
    assign row_addr_b = k;
    assign col_addr_b = j;
    assign row_addr_c = i;
    assign col_addr_c = j;

endmodule
